// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: scans a 6-digit BCD frame onto a shared active-low 7-seg bus with blanking gaps.
// Define SCAN_DIM_EN to add a 3-bit brightness input that shortens the lit part of each dwell.
`ifndef NUMBER_0
`define NUMBER_0 8'hC0
`define NUMBER_1 8'hF9
`define NUMBER_2 8'hA4
`define NUMBER_3 8'hB0
`define NUMBER_4 8'h99
`define NUMBER_5 8'h92
`define NUMBER_6 8'h82
`define NUMBER_7 8'hF8
`define NUMBER_8 8'h80
`define NUMBER_9 8'h90
`endif
module seg_scan_ctrl #(
   parameter int DWELL = 4096,
   parameter int GAP = 64,
   parameter logic [7:0] BLANK_SEG = 8'hFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [23:0] frame_bcd,
   input  logic [5:0]  dp_mask,
   input  logic        frame_valid,
`ifdef SCAN_DIM_EN
   input  logic [2:0]  brightness,
`endif
   output logic        frame_ready,
   output logic        frame_done,
   output logic [7:0]  number,
   output logic [5:0]  digit_block
);
   localparam int MX = DWELL > GAP ? DWELL : GAP;
   localparam int CW = MX > 1 ? $clog2(MX) : 1;
   typedef enum logic [1:0] {IDLE, SHOW, GAP_ST} state_t;
   state_t state, n_state;
   logic [2:0] idx, n_idx;
   logic [CW-1:0] cnt, n_cnt;
   logic [23:0] act, pend, n_act;
   logic [5:0] act_dp, pend_dp, n_dp;
   logic n_done, last, entry, swap, drive;
   logic [3:0] nib;
   function automatic logic [7:0] seg(input logic [3:0] n);
      case (n)
         4'd0: seg = `NUMBER_0;
         4'd1: seg = `NUMBER_1;
         4'd2: seg = `NUMBER_2;
         4'd3: seg = `NUMBER_3;
         4'd4: seg = `NUMBER_4;
         4'd5: seg = `NUMBER_5;
         4'd6: seg = `NUMBER_6;
         4'd7: seg = `NUMBER_7;
         4'd8: seg = `NUMBER_8;
         4'd9: seg = `NUMBER_9;
         default: seg = BLANK_SEG;
      endcase
   endfunction
`ifdef SCAN_DIM_EN
   logic [CW:0] on_len, n_on;
   int on_raw;
`endif
   always_comb begin
      last = idx == 3'd5;
      n_state = state;
      n_idx = idx;
      n_cnt = cnt + 1'b1;
      n_done = 1'b0;
      if (!enable) begin
         n_state = IDLE;
         n_idx = 3'd0;
         n_cnt = '0;
      end else begin
         case (state)
            IDLE: begin
               n_state = SHOW;
               n_idx = 3'd0;
               n_cnt = '0;
            end
            SHOW: if (cnt == CW'(DWELL - 1)) begin
               n_cnt = '0;
               if (GAP == 0) begin
                  n_idx = last ? 3'd0 : idx + 3'd1;
                  n_done = last;
               end else n_state = GAP_ST;
            end
            default: if (cnt == CW'(GAP - 1)) begin
               n_state = SHOW;
               n_cnt = '0;
               n_idx = last ? 3'd0 : idx + 3'd1;
               n_done = last;
            end
         endcase
      end
      entry = n_state == SHOW && (state != SHOW || cnt == CW'(DWELL - 1));
      swap = entry && n_idx == 3'd0 && !frame_ready;
      n_act = swap ? pend : act;
      n_dp = swap ? pend_dp : act_dp;
      nib = n_act[{n_idx, 2'b00} +: 4];
`ifdef SCAN_DIM_EN
      // lit portion is latched at SHOW entry so a brightness change never splits a dwell
      on_raw = ((int'(brightness) + 1) * DWELL) / 8;
      n_on = entry ? (CW + 1)'(on_raw < 1 ? 1 : on_raw) : on_len;
      drive = n_state == SHOW && {1'b0, n_cnt} < n_on;
`else
      drive = n_state == SHOW;
`endif
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         idx <= 3'd0;
         cnt <= '0;
         act <= 24'hFFFFFF;
         act_dp <= 6'd0;
         pend <= 24'hFFFFFF;
         pend_dp <= 6'd0;
         frame_ready <= 1'b1;
         frame_done <= 1'b0;
         number <= BLANK_SEG;
         digit_block <= 6'b111111;
`ifdef SCAN_DIM_EN
         on_len <= '0;
`endif
      end else begin
         state <= n_state;
         idx <= n_idx;
         cnt <= n_cnt;
         act <= n_act;
         act_dp <= n_dp;
         frame_done <= n_done;
         if (frame_valid && frame_ready) begin
            pend <= frame_bcd;
            pend_dp <= dp_mask;
            frame_ready <= 1'b0;
         end else if (swap) frame_ready <= 1'b1;
         number <= drive ? seg(nib) & ~{n_dp[n_idx], 7'd0} : BLANK_SEG;
         digit_block <= drive ? ~(6'b1 << n_idx) : 6'b111111;
`ifdef SCAN_DIM_EN
         on_len <= n_on;
`endif
      end
   end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: randomized bench for seg_scan_ctrl against a frame-phase reference model.
module tb_seg_scan_ctrl;
   localparam int DWELL = 4;
   localparam int GAP = 2;
   localparam int PER = DWELL + GAP;
   localparam int P = 6 * PER;
   logic clk = 1'b0, rst = 1'b0, enable = 1'b0, frame_valid = 1'b0;
   logic [23:0] frame_bcd = '0;
   logic [5:0] dp_mask = '0;
   logic frame_ready, frame_done;
   logic [7:0] number;
   logic [5:0] digit_block;
`ifdef SCAN_DIM_EN
   logic [2:0] brightness = 3'd7;
`endif
   int vectors = 0, miscompares = 0;
   bit m_run, m_pf, m_done;
   int t;
   logic [23:0] m_act, m_pend;
   logic [5:0] m_adp, m_pdp;
   seg_scan_ctrl #(.DWELL(DWELL), .GAP(GAP), .BLANK_SEG(8'hFF)) dut (
      .clk(clk), .rst(rst), .enable(enable), .frame_bcd(frame_bcd), .dp_mask(dp_mask),
      .frame_valid(frame_valid),
`ifdef SCAN_DIM_EN
      .brightness(brightness),
`endif
      .frame_ready(frame_ready), .frame_done(frame_done), .number(number), .digit_block(digit_block));
   always #5 clk = ~clk;
   function automatic logic [7:0] seg_of(input logic [3:0] n);
      case (n)
         4'd0: return 8'hC0;
         4'd1: return 8'hF9;
         4'd2: return 8'hA4;
         4'd3: return 8'hB0;
         4'd4: return 8'h99;
         4'd5: return 8'h92;
         4'd6: return 8'h82;
         4'd7: return 8'hF8;
         4'd8: return 8'h80;
         4'd9: return 8'h90;
         default: return 8'hFF;
      endcase
   endfunction
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic model_reset();
      m_run = 0; t = 0; m_pf = 0; m_done = 0;
      m_act = '1; m_pend = '1; m_adp = '0; m_pdp = '0;
   endtask
   task automatic check_out();
      int d, off;
      logic [7:0] en;
      logic [5:0] eb;
      d = t / PER;
      off = t % PER;
      en = 8'hFF;
      eb = 6'h3F;
      if (m_run && off < DWELL) begin
         eb = ~(6'b1 << d);
         en = seg_of(m_act[4*d +: 4]);
         if (m_adp[d]) en[7] = 1'b0;
      end
      chk("number", number, en);
      chk("digit_block", digit_block, eb);
      chk("frame_ready", frame_ready, !m_pf);
      chk("frame_done", frame_done, m_done);
   endtask
   task automatic step();
      bit acc;
      @(posedge clk);
      acc = frame_valid && !m_pf;
      m_done = 0;
      if (!enable) begin
         m_run = 0; t = 0;
      end else begin
         if (!m_run) begin
            m_run = 1; t = 0;
         end else begin
            t = (t + 1) % P;
            m_done = t == 0;
         end
         if (t == 0 && m_pf) begin
            m_act = m_pend; m_adp = m_pdp; m_pf = 0;
         end
      end
      if (acc) begin
         m_pend = frame_bcd; m_pdp = dp_mask; m_pf = 1;
      end
      #1 check_out();
   endtask
   task automatic offer(input logic [23:0] f, input logic [5:0] dp);
      frame_bcd = f; dp_mask = dp; frame_valid = 1'b1;
      step();
      frame_valid = 1'b0;
   endtask
   initial begin
      int dc;
      model_reset();
      #12 check_out();
      rst = 1'b1;
      repeat (3) step();
      offer(24'h123456, 6'd0);
      enable = 1'b1;
      step();
      dc = 0;
      for (int i = 0; i < P; i++) begin
         step();
         dc += int'(frame_done);
      end
      chk("done_per_frame", dc, 1);
      for (int i = 0; i < P && t / PER != 2; i++) step();
      offer(24'h000111, 6'd0);
      chk("ready_drop", frame_ready, 0);
      for (int i = 0; i < P && t != 0; i++) step();
      chk("ready_back", frame_ready, 1);
      offer(24'hA00000, 6'b000100);
      repeat (2 * P) step();
      for (int i = 0; i < P && t != 3 * PER + 1; i++) step();
      enable = 1'b0;
      step();
      enable = 1'b1;
      step();
      chk("restart_digit0", digit_block, 6'b111110);
      for (int i = 0; i < P && t / PER != 1; i++) step();
      offer(24'h987654, 6'b111111);
      for (int i = 0; i < P && t != 3 * PER + 1; i++) step();
      chk("pending_before_rst", frame_ready, 0);
      #2 rst = 1'b0;
      #1 model_reset();
      check_out();
      #2 rst = 1'b1;
      repeat (P + 6) step();
      offer(24'h135790, 6'b010101);
      repeat (2 * P) step();
      for (int i = 0; i < 3000; i++) begin
         enable = $urandom_range(0, 99) != 0;
         frame_valid = $urandom_range(0, 2) == 0;
         frame_bcd = 24'($urandom);
         dp_mask = 6'($urandom);
         step();
         if ($urandom_range(0, 499) == 0) begin
            #2 rst = 1'b0;
            #1 model_reset();
            check_out();
            #2 rst = 1'b1;
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
